// File: rtl/cmos_frame_writer_pkg.sv
// -----------------------------------------------------------------------------
// cmos_frame_writer_pkg
// Shared definitions for the CMOS frame writer:
//   - wr_state_e : burst-writer FSM state encoding
//   - ERR_*      : bit positions inside the sticky error vector
//   - DEF_*      : default frame geometry (640x480 VGA)
// -----------------------------------------------------------------------------
package cmos_frame_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_REQ,
    ST_BURST,
    ST_FLUSH
  } wr_state_e;

  localparam int ERR_OVF = 0;  // pixel dropped because the FIFO was full
  localparam int ERR_CNT = 1;  // frame pixel count differed from FRAME_PIXELS

  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_FRAME_PIXELS = DEF_H_ACTIVE * DEF_V_ACTIVE;  // 307200

endpackage

// File: rtl/cmos_pix_fifo.sv
// -----------------------------------------------------------------------------
// cmos_pix_fifo
// Single-clock synchronous FIFO with a registered read port.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (drops all stored words)
//   push/push_data : write one word when not full
//   pop/pop_data   : read one word when not empty; pop_data updates the
//                    cycle after pop (registered output)
//   level      : current occupancy, 0..DEPTH
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module cmos_pix_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & ~empty & ~clr;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_data_d = mem[rd_ptr_q];
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking
  // assignments stay in always_comb where ordering is intended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and level
  // alone define which entries are valid, which lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = rd_data_q;
  assign level    = level_q;

endmodule

// File: rtl/cmos_frame_writer.sv
// -----------------------------------------------------------------------------
// cmos_frame_writer
// Buffers RGB565 pixels from the CMOS capture stage and writes them to SDRAM
// in fixed-length bursts, alternating between two frame banks so the display
// always reads a complete frame.
//   iCLK, iRST_N           : pixel clock, async active-low reset
//   iFRAME_VALID           : frame envelope level
//   iPIX_VALID, iPIX_DATA  : pixel strobe and data
//   oWR_REQ, oWR_ADDR      : burst request and start address
//   iWR_ACK                : one-cycle burst grant
//   iWR_DATA_REQ, oWR_DATA : per-word pull, data valid one cycle later
//   oFRAME_DONE            : pulse when a complete frame is committed
//   oRD_BANK               : bank the display must read
//   oERR                   : sticky {count mismatch, FIFO overflow}
//   oFIFO_LEVEL            : pixel FIFO occupancy
// -----------------------------------------------------------------------------
module cmos_frame_writer
  import cmos_frame_writer_pkg::*;
#(
  parameter int          BURST_LEN    = 256,
  parameter int          FIFO_DEPTH   = 512,
  parameter int          FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int          ADDR_W       = 22,
  parameter int unsigned BANK_STRIDE  = 32'h0008_0000
) (
  input  logic                          iCLK,
  input  logic                          iRST_N,
  input  logic                          iFRAME_VALID,
  input  logic                          iPIX_VALID,
  input  logic [15:0]                   iPIX_DATA,
  output logic                          oWR_REQ,
  output logic [ADDR_W-1:0]             oWR_ADDR,
  input  logic                          iWR_ACK,
  input  logic                          iWR_DATA_REQ,
  output logic [15:0]                   oWR_DATA,
  output logic                          oFRAME_DONE,
  output logic                          oRD_BANK,
  output logic [1:0]                    oERR,
  output logic [$clog2(FIFO_DEPTH):0]   oFIFO_LEVEL
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam int BC_W  = $clog2(BURST_LEN);

  wr_state_e         state_q, state_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_active_q, frame_active_d;
  logic              frame_end_q, frame_end_d;
  logic              ovf_frame_q, ovf_frame_d;
  logic              excess_q, excess_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic              wr_req_q, wr_req_d;
  logic              done_q, done_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        err_q, err_d;

  logic              fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
  logic [15:0]       fifo_rdata;
  logic [LVL_W-1:0]  fifo_level;

  logic frame_rise, frame_fall, pix_in, cnt_ok, burst_last, level_ge_burst;
  logic ended, cnt_mismatch;

  assign frame_rise     = iFRAME_VALID & ~frame_valid_q;
  assign frame_fall     = ~iFRAME_VALID & frame_valid_q;
  assign pix_in         = iPIX_VALID & frame_active_q;
  assign cnt_ok         = (pix_cnt_q < CNT_W'(FRAME_PIXELS));
  assign fifo_push      = pix_in & cnt_ok & ~fifo_full;
  // Data requests outside BURST are ignored.
  assign fifo_pop       = (state_q == ST_BURST) & iWR_DATA_REQ & ~fifo_empty;
  assign fifo_clr       = (state_q == ST_FLUSH);
  assign burst_last     = fifo_pop & (burst_cnt_q == BC_W'(BURST_LEN - 1));
  assign level_ge_burst = (fifo_level >= LVL_W'(BURST_LEN));
  // Frame end seen now or latched earlier while a burst was in flight.
  assign ended          = frame_end_q | (frame_active_q & frame_fall);
  assign cnt_mismatch   = (pix_cnt_q != CNT_W'(FRAME_PIXELS)) | excess_q;

  cmos_pix_fifo #(
    .DW    (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (iCLK),
    .rst_n     (iRST_N),
    .clr       (fifo_clr),
    .push      (fifo_push),
    .push_data (iPIX_DATA),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d        = state_q;
    frame_valid_d  = iFRAME_VALID;
    frame_active_d = frame_active_q;
    frame_end_d    = frame_end_q;
    ovf_frame_d    = ovf_frame_q;
    excess_d       = excess_q;
    pix_cnt_d      = pix_cnt_q;
    addr_d         = addr_q;
    burst_cnt_d    = burst_cnt_q;
    wr_req_d       = wr_req_q;
    done_d         = 1'b0;
    wr_bank_d      = wr_bank_q;
    rd_bank_d      = rd_bank_q;
    err_d          = err_q;

    if (pix_in) begin
      if (fifo_full) begin
        err_d[ERR_OVF] = 1'b1;
        ovf_frame_d    = 1'b1;
      end
      // Surplus pixels are only reported when the frame is evaluated.
      if (!cnt_ok) excess_d = 1'b1;
    end
    if (fifo_push) pix_cnt_d = pix_cnt_q + 1'b1;
    // Counter wraps to zero after BURST_LEN pops, ready for the next burst.
    if (fifo_pop) burst_cnt_d = burst_cnt_q + 1'b1;
    if (frame_active_q && frame_fall) begin
      frame_active_d = 1'b0;
      frame_end_d    = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_rise) begin
          state_d        = ST_FILL;
          frame_active_d = 1'b1;
          frame_end_d    = 1'b0;
          ovf_frame_d    = 1'b0;
          excess_d       = 1'b0;
          pix_cnt_d      = '0;
          addr_d         = wr_bank_q ? ADDR_W'(BANK_STRIDE) : '0;
        end
      end
      ST_FILL: begin
        if (level_ge_burst) begin
          state_d  = ST_REQ;
          wr_req_d = 1'b1;
        end else if (ended) begin
          state_d = ST_FLUSH;
        end
      end
      ST_REQ: begin
        if (iWR_ACK) begin
          state_d  = ST_BURST;
          wr_req_d = 1'b0;
        end
      end
      ST_BURST: begin
        if (burst_last) begin
          addr_d  = addr_q + ADDR_W'(BURST_LEN);
          state_d = (ended && !level_ge_burst) ? ST_FLUSH : ST_FILL;
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        if (!cnt_mismatch && !ovf_frame_q) begin
          rd_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
          done_d    = 1'b1;
        end else if (cnt_mismatch) begin
          err_d[ERR_CNT] = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q        <= ST_IDLE;
      frame_valid_q  <= 1'b0;
      frame_active_q <= 1'b0;
      frame_end_q    <= 1'b0;
      ovf_frame_q    <= 1'b0;
      excess_q       <= 1'b0;
      pix_cnt_q      <= '0;
      addr_q         <= '0;
      burst_cnt_q    <= '0;
      wr_req_q       <= 1'b0;
      done_q         <= 1'b0;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b1;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      frame_valid_q  <= frame_valid_d;
      frame_active_q <= frame_active_d;
      frame_end_q    <= frame_end_d;
      ovf_frame_q    <= ovf_frame_d;
      excess_q       <= excess_d;
      pix_cnt_q      <= pix_cnt_d;
      addr_q         <= addr_d;
      burst_cnt_q    <= burst_cnt_d;
      wr_req_q       <= wr_req_d;
      done_q         <= done_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      err_q          <= err_d;
    end
  end

  assign oWR_REQ     = wr_req_q;
  assign oWR_ADDR    = addr_q;
  assign oWR_DATA    = fifo_rdata;
  assign oFRAME_DONE = done_q;
  assign oRD_BANK    = rd_bank_q;
  assign oERR        = err_q;
  assign oFIFO_LEVEL = fifo_level;

endmodule

// File: tb/tb_cmos_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_cmos_frame_writer
// Directed bench for cmos_frame_writer with a reduced 512-pixel frame.
// A background SDRAM responder grants every request in the cycle it appears
// and pulls BURST_LEN words (continuously, gapped, or held off).
// -----------------------------------------------------------------------------
module tb_cmos_frame_writer;

  localparam int BURST_LEN    = 256;
  localparam int FIFO_DEPTH   = 512;
  localparam int FRAME_PIXELS = 512;
  localparam int ADDR_W       = 22;
  localparam logic [21:0] STRIDE = 22'h080000;

  logic        clk;
  logic        rst_n;
  logic        frame_valid;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        wr_req;
  logic [21:0] wr_addr;
  logic        wr_ack;
  logic        wr_data_req;
  logic [15:0] wr_data;
  logic        frame_done;
  logic        rd_bank;
  logic [1:0]  err;
  logic [9:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  cmos_frame_writer #(
    .BURST_LEN    (BURST_LEN),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .FRAME_PIXELS (FRAME_PIXELS),
    .ADDR_W       (ADDR_W),
    .BANK_STRIDE  (32'h0008_0000)
  ) dut (
    .iCLK         (clk),
    .iRST_N       (rst_n),
    .iFRAME_VALID (frame_valid),
    .iPIX_VALID   (pix_valid),
    .iPIX_DATA    (pix_data),
    .oWR_REQ      (wr_req),
    .oWR_ADDR     (wr_addr),
    .iWR_ACK      (wr_ack),
    .iWR_DATA_REQ (wr_data_req),
    .oWR_DATA     (wr_data),
    .oFRAME_DONE  (frame_done),
    .oRD_BANK     (rd_bank),
    .oERR         (err),
    .oFIFO_LEVEL  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SDRAM responder and monitors (written only here)
  int          sd_mode = 0;     // 0: continuous pull, 1: gapped 1,0,1,1 pattern
  bit          sd_hold = 1'b0;  // hold off all data requests
  int          sd_left = 0;
  int          sd_step = 0;
  logic [21:0] burst_addr[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    wr_ack      = 1'b0;
    wr_data_req = 1'b0;
    if (frame_done === 1'b1) done_cnt++;
    if (!rst_n) begin
      sd_left = 0;
    end else if (sd_left > 0) begin
      if (!sd_hold && (sd_mode == 0 || (sd_step % 4) != 1)) begin
        wr_data_req = 1'b1;
        sd_left--;
      end
      sd_step++;
    end else if (wr_req === 1'b1) begin
      wr_ack  = 1'b1;
      sd_left = BURST_LEN;
      sd_step = 0;
      burst_addr.push_back(wr_addr);
    end
  end

  // Stimulus helpers
  task automatic apply_reset();
    rst_n       = 1'b0;
    frame_valid = 1'b0;
    pix_valid   = 1'b0;
    pix_data    = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame_begin();
    frame_valid = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One pixel every second cycle, data equal to the pixel index.
  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data  = 16'(i);
      @(negedge clk);
      pix_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic frame_stop();
    repeat (2) @(negedge clk);
    frame_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input int n);
    frame_begin();
    send_pixels(n);
    frame_stop();
  endtask

  // Tests
  task automatic test_reset();
    rst_n       = 1'b0;
    frame_valid = 1'b0;
    pix_valid   = 1'b0;
    pix_data    = 16'h0000;
    repeat (3) @(negedge clk);
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL rst_wr_req: got %0h expected 0", wr_req); end
    total++; if (wr_addr !== 22'h0) begin bad++; $display("FAIL rst_wr_addr: got %0h expected 0", wr_addr); end
    total++; if (wr_data !== 16'h0) begin bad++; $display("FAIL rst_wr_data: got %0h expected 0", wr_data); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0h expected 0", frame_done); end
    total++; if (rd_bank !== 1'b1) begin bad++; $display("FAIL rst_rd_bank: got %0h expected 1", rd_bank); end
    total++; if (err !== 2'b00) begin bad++; $display("FAIL rst_err: got %0h expected 0", err); end
    total++; if (fifo_level !== 10'd0) begin bad++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_frame();
    int b0, d0;
    apply_reset();
    sd_mode = 0;
    b0 = burst_addr.size();
    d0 = done_cnt;
    send_frame(FRAME_PIXELS);
    repeat (700) @(negedge clk);
    total++; if (burst_addr.size() - b0 != 2) begin bad++; $display("FAIL full_bursts: got %0d expected 2", burst_addr.size() - b0); end
    total++; if (burst_addr[b0] !== 22'h0) begin bad++; $display("FAIL full_addr0: got %0h expected 0", burst_addr[b0]); end
    total++; if (burst_addr[b0+1] !== 22'h100) begin bad++; $display("FAIL full_addr1: got %0h expected 100", burst_addr[b0+1]); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL full_done: got %0d expected 1", done_cnt - d0); end
    total++; if (rd_bank !== 1'b0) begin bad++; $display("FAIL full_rd_bank: got %0h expected 0", rd_bank); end
    total++; if (err !== 2'b00) begin bad++; $display("FAIL full_err: got %0h expected 0", err); end
    total++; if (fifo_level !== 10'd0) begin bad++; $display("FAIL full_level: got %0d expected 0", fifo_level); end
    // Second frame lands in bank 1 and flips the display back.
    b0 = burst_addr.size();
    send_frame(FRAME_PIXELS);
    repeat (700) @(negedge clk);
    total++; if (burst_addr.size() - b0 != 2) begin bad++; $display("FAIL full2_bursts: got %0d expected 2", burst_addr.size() - b0); end
    total++; if (burst_addr[b0] !== STRIDE) begin bad++; $display("FAIL full2_addr0: got %0h expected %0h", burst_addr[b0], STRIDE); end
    total++; if (burst_addr[b0+1] !== STRIDE + 22'h100) begin bad++; $display("FAIL full2_addr1: got %0h expected %0h", burst_addr[b0+1], STRIDE + 22'h100); end
    total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL full2_done: got %0d expected 2", done_cnt - d0); end
    total++; if (rd_bank !== 1'b1) begin bad++; $display("FAIL full2_rd_bank: got %0h expected 1", rd_bank); end
  endtask

  task automatic test_overflow();
    int b0, d0;
    apply_reset();
    sd_mode = 0;
    sd_hold = 1'b1;
    b0 = burst_addr.size();
    d0 = done_cnt;
    frame_begin();
    send_pixels(FRAME_PIXELS + 8);
    total++; if (fifo_level !== 10'd512) begin bad++; $display("FAIL ovf_level_full: got %0d expected 512", fifo_level); end
    total++; if (err[0] !== 1'b1) begin bad++; $display("FAIL ovf_err0: got %0h expected 1", err[0]); end
    frame_stop();
    sd_hold = 1'b0;
    repeat (900) @(negedge clk);
    total++; if (burst_addr.size() - b0 != 2) begin bad++; $display("FAIL ovf_bursts: got %0d expected 2", burst_addr.size() - b0); end
    total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL ovf_done: got %0d expected 0", done_cnt - d0); end
    total++; if (rd_bank !== 1'b1) begin bad++; $display("FAIL ovf_rd_bank: got %0h expected 1", rd_bank); end
    total++; if (err[0] !== 1'b1) begin bad++; $display("FAIL ovf_err0_sticky: got %0h expected 1", err[0]); end
    total++; if (fifo_level !== 10'd0) begin bad++; $display("FAIL ovf_level_end: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_short_frame();
    int b0, d0;
    apply_reset();
    sd_mode = 0;
    b0 = burst_addr.size();
    d0 = done_cnt;
    frame_begin();
    send_pixels(400);
    total++; if (fifo_level !== 10'd144) begin bad++; $display("FAIL short_residual: got %0d expected 144", fifo_level); end
    frame_stop();
    repeat (50) @(negedge clk);
    total++; if (fifo_level !== 10'd0) begin bad++; $display("FAIL short_flushed: got %0d expected 0", fifo_level); end
    total++; if (burst_addr.size() - b0 != 1) begin bad++; $display("FAIL short_bursts: got %0d expected 1", burst_addr.size() - b0); end
    total++; if (burst_addr[b0] !== 22'h0) begin bad++; $display("FAIL short_addr: got %0h expected 0", burst_addr[b0]); end
    total++; if (err !== 2'b10) begin bad++; $display("FAIL short_err: got %0h expected 2", err); end
    total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL short_done: got %0d expected 0", done_cnt - d0); end
    total++; if (rd_bank !== 1'b1) begin bad++; $display("FAIL short_rd_bank: got %0h expected 1", rd_bank); end
  endtask

  task automatic test_long_frame();
    int b0, d0;
    apply_reset();
    sd_mode = 0;
    b0 = burst_addr.size();
    d0 = done_cnt;
    send_frame(600);
    repeat (700) @(negedge clk);
    total++; if (burst_addr.size() - b0 != 2) begin bad++; $display("FAIL long_bursts: got %0d expected 2", burst_addr.size() - b0); end
    total++; if (burst_addr[b0+1] !== 22'h100) begin bad++; $display("FAIL long_addr1: got %0h expected 100", burst_addr[b0+1]); end
    total++; if (err !== 2'b10) begin bad++; $display("FAIL long_err: got %0h expected 2", err); end
    total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL long_done: got %0d expected 0", done_cnt - d0); end
    total++; if (rd_bank !== 1'b1) begin bad++; $display("FAIL long_rd_bank: got %0h expected 1", rd_bank); end
  endtask

  task automatic test_gapped_data();
    int d0, nexp;
    apply_reset();
    sd_mode = 1;
    d0 = done_cnt;
    nexp = 0;
    fork
      send_frame(FRAME_PIXELS);
      begin
        // A request sampled at a rising edge yields its word just after it.
        for (int cyc = 0; cyc < 6000 && nexp < FRAME_PIXELS; cyc++) begin
          @(posedge clk);
          #1;
          if (wr_data_req === 1'b1) begin
            total++;
            if (wr_data !== 16'(nexp)) begin
              bad++;
              $display("FAIL gap_word%0d: got %0h expected %0h", nexp, wr_data, 16'(nexp));
            end
            nexp++;
          end
        end
      end
    join
    repeat (100) @(negedge clk);
    total++; if (nexp != FRAME_PIXELS) begin bad++; $display("FAIL gap_word_count: got %0d expected %0d", nexp, FRAME_PIXELS); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL gap_done: got %0d expected 1", done_cnt - d0); end
    total++; if (rd_bank !== 1'b0) begin bad++; $display("FAIL gap_rd_bank: got %0h expected 0", rd_bank); end
    sd_mode = 0;
  endtask

  task automatic test_reset_mid_burst();
    int b0, d0;
    bit seen;
    apply_reset();
    sd_mode = 0;
    send_frame(FRAME_PIXELS);
    repeat (700) @(negedge clk);
    total++; if (rd_bank !== 1'b0) begin bad++; $display("FAIL mid_pre_rd_bank: got %0h expected 0", rd_bank); end
    b0 = burst_addr.size();
    seen = 1'b0;
    fork
      begin
        frame_begin();
        send_pixels(300);
        frame_stop();
      end
      begin
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
          @(negedge clk);
          if (burst_addr.size() > b0) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL mid_burst_timeout: got 0 bursts expected 1"); end
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL mid_wr_req: got %0h expected 0", wr_req); end
        total++; if (wr_addr !== 22'h0) begin bad++; $display("FAIL mid_wr_addr: got %0h expected 0", wr_addr); end
        total++; if (wr_data !== 16'h0) begin bad++; $display("FAIL mid_wr_data: got %0h expected 0", wr_data); end
        total++; if (rd_bank !== 1'b1) begin bad++; $display("FAIL mid_rd_bank: got %0h expected 1", rd_bank); end
        total++; if (err !== 2'b00) begin bad++; $display("FAIL mid_err: got %0h expected 0", err); end
        total++; if (fifo_level !== 10'd0) begin bad++; $display("FAIL mid_level: got %0d expected 0", fifo_level); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL mid_done: got %0h expected 0", frame_done); end
        // Keep reset asserted until the interrupted frame has ended.
        for (int cyc = 0; cyc < 2000 && frame_valid; cyc++) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
      end
    join
    total++; if (burst_addr[b0] !== STRIDE) begin bad++; $display("FAIL mid_pre_addr: got %0h expected %0h", burst_addr[b0], STRIDE); end
    b0 = burst_addr.size();
    d0 = done_cnt;
    send_frame(FRAME_PIXELS);
    repeat (700) @(negedge clk);
    total++; if (burst_addr.size() - b0 != 2) begin bad++; $display("FAIL mid_post_bursts: got %0d expected 2", burst_addr.size() - b0); end
    total++; if (burst_addr[b0] !== 22'h0) begin bad++; $display("FAIL mid_post_addr: got %0h expected 0", burst_addr[b0]); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL mid_post_done: got %0d expected 1", done_cnt - d0); end
    total++; if (rd_bank !== 1'b0) begin bad++; $display("FAIL mid_post_rd_bank: got %0h expected 0", rd_bank); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_overflow();
    test_short_frame();
    test_long_frame();
    test_gapped_data();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
